sign_narrow_16to4: RTL

//  Inverse of the 4->16 sign extender: narrows a 16-bit signed datapath value to a 4-bit signed field.

---
 rtl/sign_narrow_16to4_pkg.sv | 19 +
 rtl/sign_narrow_16to4_skid_buffer_2entry.sv | 69 ++++++
 rtl/sign_narrow_16to4.sv | 100 ++++++++++
 3 files changed

// File: rtl/sign_narrow_16to4_pkg.sv
// Shared constants and helpers for the 4-bit immediate narrowing/extension datapath.
package sign_narrow_16to4_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM4_W = 4;

    // True when the value fits in a signed IMM4_W field (upper bits all equal the field sign bit).
    function automatic logic in_range(input logic [DATA_W-1:0] value);
        logic [DATA_W-IMM4_W:0] hi;
        hi = value[DATA_W-1:IMM4_W-1];
        return (&hi) | ~(|hi);
    endfunction

    // Clamp value for an out-of-range word: most negative for sign=1, most positive otherwise.
    function automatic logic [IMM4_W-1:0] sat_value(input logic sign);
        return sign ? {1'b1, {(IMM4_W-1){1'b0}}} : {1'b0, {(IMM4_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/sign_narrow_16to4_skid_buffer_2entry.sv
// Valid/ready pipeline stage: output register plus one skid entry, registered in_ready.
module skid_buffer_2entry #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_full;
    logic [W-1:0] skid_data;

    logic         out_valid_n;
    logic [W-1:0] out_data_n;
    logic         skid_full_n;
    logic [W-1:0] skid_data_n;
    logic         in_ready_n;
    logic         accept;

    // Next-state: refill output from skid first, else from input; park input in skid when output stalls.
    always_comb begin
        out_valid_n = out_valid;
        out_data_n  = out_data;
        skid_full_n = skid_full;
        skid_data_n = skid_data;
        accept      = in_valid && in_ready;

        if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_valid_n = 1'b1;
                out_data_n  = skid_data;
                skid_full_n = 1'b0;
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_data_n  = in_data;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_full_n = 1'b1;
            skid_data_n = in_data;
        end

        in_ready_n = !skid_full_n;
    end

    // State registers; in_ready comes up on the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            in_ready  <= 1'b0;
        end else begin
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            skid_full <= skid_full_n;
            skid_data <= skid_data_n;
            in_ready  <= in_ready_n;
        end
    end

endmodule

// File: rtl/sign_narrow_16to4.sv
// Narrows a signed datapath word to a signed immediate field, with saturation flag and overflow stats.
module sign_narrow_16to4
    import sign_narrow_16to4_pkg::*;
#(
    parameter int unsigned IN_W     = DATA_W,
    parameter int unsigned OUT_W    = IMM4_W,
    parameter int unsigned CNT_W    = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  Data_In,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] Data_Out,
    output logic             out_sat,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_ovf
);

    localparam int unsigned HI_W = IN_W - OUT_W + 1;

    logic             in_rng;
    logic [OUT_W-1:0] sat_val;
    logic [OUT_W:0]   narrow_word;
    logic [OUT_W:0]   buf_word;
    logic             accept;
    logic             ovf_sticky_n;
    logic [CNT_W-1:0] ovf_count_n;

    // Range test and clamp value: shared helpers at default widths, generic form otherwise.
    generate
        if (IN_W == DATA_W && OUT_W == IMM4_W) begin : g_pkg_fn
            assign in_rng  = in_range(Data_In);
            assign sat_val = sat_value(Data_In[IN_W-1]);
        end else begin : g_generic
            logic [HI_W-1:0] hi;
            assign hi      = Data_In[IN_W-1:OUT_W-1];
            assign in_rng  = (&hi) | ~(|hi);
            assign sat_val = Data_In[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}};
        end
    endgenerate

    // Narrowed payload {sat flag, field}: clamp or plain truncation depending on SATURATE.
    always_comb begin
        narrow_word = {~in_rng, Data_In[OUT_W-1:0]};
        if (SATURATE && !in_rng) begin
            narrow_word[OUT_W-1:0] = sat_val;
        end
    end

    skid_buffer_2entry #(
        .W (OUT_W + 1)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (narrow_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_word)
    );

    assign Data_Out = buf_word[OUT_W-1:0];
    assign out_sat  = buf_word[OUT_W];

    // Overflow bookkeeping at accept time; a same-edge out-of-range accept wins over clear.
    always_comb begin
        accept       = in_valid && in_ready;
        ovf_sticky_n = ovf_sticky;
        ovf_count_n  = ovf_count;
        if (clr_ovf) begin
            ovf_sticky_n = 1'b0;
            ovf_count_n  = '0;
        end
        if (accept && !in_rng) begin
            ovf_sticky_n = 1'b1;
            if (ovf_count_n != '1) begin
                ovf_count_n = ovf_count_n + CNT_W'(1);
            end
        end
    end

    // Overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else begin
            ovf_sticky <= ovf_sticky_n;
            ovf_count  <= ovf_count_n;
        end
    end

endmodule
